// File: rtl/jtag_host_pkg.sv
// Shared types and TMS walk constants for the fabric-side JTAG initiator.
package jtag_host_pkg;

    typedef enum logic [1:0] {
        CMD_RESET = 2'd0,
        CMD_IR    = 2'd1,
        CMD_DR    = 2'd2,
        CMD_RSVD  = 2'd3
    } cmd_type_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WALK_IN,
        ST_SHIFT,
        ST_WALK_OUT,
        ST_RSP
    } state_e;

    // TMS walk patterns, bit 0 is driven first.
    localparam logic [7:0] RESET_TMS  = 8'b0001_1111;  // 1,1,1,1,1,0
    localparam logic [7:0] DR_IN_TMS  = 8'b0000_0001;  // 1,0,0
    localparam logic [7:0] IR_IN_TMS  = 8'b0000_0011;  // 1,1,0,0
    localparam logic [7:0] OUT_TMS    = 8'b0000_0001;  // 1,0

    localparam logic [5:0] RESET_LEN  = 6'd6;
    localparam logic [5:0] DR_IN_LEN  = 6'd3;
    localparam logic [5:0] IR_IN_LEN  = 6'd4;
    localparam logic [5:0] OUT_LEN    = 6'd2;

endpackage

// File: rtl/jtag_host_if.sv
// Command/response channel of the JTAG initiator.
interface jtag_host_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [4:0]  cmd_len_m1;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;

    modport master (
        output cmd_valid, cmd_type, cmd_len_m1, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_len_m1, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/jtag_tck_gen.sv
// TCK divider: CLK_DIV cycles low then CLK_DIV cycles high, restarting low on enable.
module jtag_tck_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tck,
    output logic tck_rise,
    output logic tck_fall
);

    localparam int unsigned CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] TERM = CW'(CLK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tck_q, tck_d;
    logic          wrap;

    // The enable is seen one cycle after accept, so the first low phase starts
    // counting from 0 and every later phase reloads to 1; this keeps the first
    // rise at accept+1+CLK_DIV and every phase CLK_DIV cycles long.
    always_comb begin
        wrap     = en && (cnt_q == TERM);
        tck_rise = wrap && !tck_q;
        tck_fall = wrap && tck_q;
        cnt_d    = '0;
        tck_d    = 1'b0;
        if (en) begin
            cnt_d = wrap ? CW'(1) : cnt_q + CW'(1);
            tck_d = tck_q ^ wrap;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tck_q <= tck_d;
        end
    end

    assign tck = tck_q;

endmodule

// File: rtl/jtag_host.sv
// Fabric-side JTAG initiator: TAP reset, IR scan and DR scan of 1..32 bits.
module jtag_host
    import jtag_host_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic            sys_clk,
    input  logic            rst,
    jtag_host_if.slave      bus,
    output logic            jtag_tck,
    output logic            jtag_tms,
    output logic            jtag_tdi,
    input  logic            jtag_tdo
);

    state_e      state_q, state_d;
    logic        is_reset_q, is_reset_d;
    logic [5:0]  len_q, len_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  walk_pat_q, walk_pat_d;
    logic [31:0] data_q, data_d;
    logic [31:0] cap_q, cap_d;
    logic        tms_q, tms_d;
    logic        tdi_q, tdi_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;

    logic        tck_en;
    logic        tck_rise;
    logic        tck_fall;
    logic [4:0]  shift_idx;
    logic [7:0]  in_pat;
    logic [5:0]  in_len;

    assign tck_en = (state_q == ST_WALK_IN) || (state_q == ST_SHIFT) || (state_q == ST_WALK_OUT);

    jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
        .clk      (sys_clk),
        .rst      (rst),
        .en       (tck_en),
        .tck      (jtag_tck),
        .tck_rise (tck_rise),
        .tck_fall (tck_fall)
    );

    // Next-state logic: each state advances one bit per TCK falling edge.
    always_comb begin
        state_d     = state_q;
        is_reset_d  = is_reset_q;
        len_d       = len_q;
        bit_cnt_d   = bit_cnt_q;
        walk_pat_d  = walk_pat_q;
        data_d      = data_q;
        cap_d       = cap_q;
        tms_d       = tms_q;
        tdi_d       = tdi_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        shift_idx   = 5'(len_q - bit_cnt_q - 6'd1);
        in_pat      = RESET_TMS;
        in_len      = RESET_LEN;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    case (cmd_type_e'(bus.cmd_type))
                        CMD_IR: begin
                            in_pat = IR_IN_TMS;
                            in_len = IR_IN_LEN;
                        end
                        CMD_DR: begin
                            in_pat = DR_IN_TMS;
                            in_len = DR_IN_LEN;
                        end
                        default: begin
                            in_pat = RESET_TMS;
                            in_len = RESET_LEN;
                        end
                    endcase
                    is_reset_d  = (bus.cmd_type != CMD_IR) && (bus.cmd_type != CMD_DR);
                    len_d       = {1'b0, bus.cmd_len_m1} + 6'd1;
                    data_d      = bus.cmd_data;
                    cap_d       = '0;
                    tms_d       = in_pat[0];
                    tdi_d       = 1'b0;
                    walk_pat_d  = in_pat >> 1;
                    bit_cnt_d   = in_len - 6'd1;
                    cmd_ready_d = 1'b0;
                    state_d     = ST_WALK_IN;
                end
            end

            ST_WALK_IN: begin
                if (tck_fall) begin
                    if (bit_cnt_q != 6'd0) begin
                        tms_d      = walk_pat_q[0];
                        walk_pat_d = walk_pat_q >> 1;
                        bit_cnt_d  = bit_cnt_q - 6'd1;
                    end else if (is_reset_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        state_d     = ST_RSP;
                    end else begin
                        tms_d     = (len_q == 6'd1);
                        tdi_d     = data_q[0];
                        data_d    = data_q >> 1;
                        bit_cnt_d = len_q - 6'd1;
                        state_d   = ST_SHIFT;
                    end
                end
            end

            ST_SHIFT: begin
                if (tck_rise) begin
                    cap_d[shift_idx] = jtag_tdo;
                end
                if (tck_fall) begin
                    if (bit_cnt_q != 6'd0) begin
                        tms_d     = (bit_cnt_q == 6'd1);
                        tdi_d     = data_q[0];
                        data_d    = data_q >> 1;
                        bit_cnt_d = bit_cnt_q - 6'd1;
                    end else begin
                        tms_d      = OUT_TMS[0];
                        tdi_d      = 1'b0;
                        walk_pat_d = OUT_TMS >> 1;
                        bit_cnt_d  = OUT_LEN - 6'd1;
                        state_d    = ST_WALK_OUT;
                    end
                end
            end

            ST_WALK_OUT: begin
                if (tck_fall) begin
                    if (bit_cnt_q != 6'd0) begin
                        tms_d      = walk_pat_q[0];
                        walk_pat_d = walk_pat_q >> 1;
                        bit_cnt_d  = bit_cnt_q - 6'd1;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = cap_q;
                        state_d     = ST_RSP;
                    end
                end
            end

            ST_RSP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            is_reset_q  <= 1'b0;
            len_q       <= '0;
            bit_cnt_q   <= '0;
            walk_pat_q  <= '0;
            data_q      <= '0;
            cap_q       <= '0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            is_reset_q  <= is_reset_d;
            len_q       <= len_d;
            bit_cnt_q   <= bit_cnt_d;
            walk_pat_q  <= walk_pat_d;
            data_q      <= data_d;
            cap_q       <= cap_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign jtag_tms      = tms_q;
    assign jtag_tdi      = tdi_q;
    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

endmodule

// File: doc/jtag_host.md
# jtag_host

Fabric-side JTAG initiator that drives the NEORV32 on-chip debug TAP (`jtag_tck/tms/tdi`) and samples `jtag_tdo`. It accepts one command at a time over a valid/ready interface: TAP reset, IR scan or DR scan of 1–32 bits. It generates the TMS walk, shifts TDI LSB-first, captures TDO and returns it on a valid/ready response channel. It lets on-FPGA logic or a bench talk to the debug module without an external probe.

## Interface
- `CLK_DIV`, default 4: TCK half-period in `sys_clk` cycles; legal ≥ 2.
- `sys_clk` in 1: sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: block idle and able to accept.
- `cmd_type` in 2: 0 = RESET, 1 = IR scan, 2 = DR scan, 3 = treated as RESET.
- `cmd_len_m1` in 5: scan length minus one (1..32 bits); ignored for RESET.
- `cmd_data` in 32: TDI bits, bit 0 shifted first.
- `rsp_valid` out 1: response held until accepted.
- `rsp_ready` in 1: response consumer ready.
- `rsp_data` out 32: captured TDO, bit i = i-th shifted bit; bits ≥ len are 0; 0 for RESET.
- `jtag_tck`, `jtag_tms`, `jtag_tdi` out 1: to TAP.
- `jtag_tdo` in 1: from TAP.

## Operation
- FSM states: IDLE, WALK_IN, SHIFT, WALK_OUT, RSP. RESET uses WALK_IN only.
- IDLE: `cmd_ready`=1. On `cmd_valid && cmd_ready`, latch type/len/data, set `cmd_ready`=0 and go to WALK_IN.
- Every state except IDLE and RSP consumes whole TCK periods. TMS/TDI change only at TCK falling edges, or at entry for the first bit. TDO is sampled on the `sys_clk` edge where TCK rises.
- RESET: TMS = 1,1,1,1,1,0 (6 TCK). Ends in Run-Test/Idle from any TAP state.
- DR scan: TMS = 1,0,0 (Select-DR, Capture, Shift). Then n shift cycles: TMS=0 except the last, which has TMS=1. Then TMS = 1,0 (Update, Idle). Total n+5 TCK.
- IR scan: TMS = 1,1,0,0, then shift as for DR, then 1,0. Total n+6 TCK.
- TDI = 0 outside shift cycles. TDO is captured only during shift cycles, into bit index 0..n-1.
- All scans assume the TAP starts in Run-Test/Idle and return it there.
- RSP: `rsp_valid`=1 and `rsp_data` stable until `rsp_valid && rsp_ready`. Then go to IDLE; `cmd_ready` rises on the next cycle.
- A new command is never accepted while a response is pending.
- Length arithmetic: n = `cmd_len_m1` + 1, held in a 6-bit counter. No wrap.

## Timing
- Reset values: `jtag_tck`=0, `jtag_tms`=1, `jtag_tdi`=0, `cmd_ready`=1, `rsp_valid`=0, `rsp_data`=0. FSM=IDLE, divider=0.
- TCK idles low. Each period is `CLK_DIV` cycles low, then `CLK_DIV` cycles high. Period = 2·`CLK_DIV`.
- Accept edge = cycle 0. First TMS/TDI valid from cycle 1. First TCK rise at cycle 1+`CLK_DIV`.
- The k-th falling edge (k ≥ 1) is at cycle 1+2k·`CLK_DIV`.
- `rsp_valid` asserts at the edge of the final TCK fall. For N TCK periods it is visible from cycle 1+2N·`CLK_DIV`.
- `rst` mid-command forces all outputs to reset values immediately. It drops any pending response, and the TAP state is undefined afterwards. Users issue RESET next.
- `cmd_valid` changes while `cmd_ready`=0 have no effect. Command fields are sampled only at accept.

## Structure
- Package `jtag_host_pkg`: `cmd_type_e` enum, FSM state enum, constants for the TMS walk-in/walk-out patterns and lengths (RESET 6, DR-in 3, IR-in 4, out 2).
- Sub-module `jtag_tck_gen`: divider producing `jtag_tck` plus single-cycle `tck_rise` and `tck_fall` strobes. It runs only while enabled and restarts low on enable.

## Test plan
Benches use a behavioural TAP model: 5-bit IR, IDCODE 0x1234_5679 selected after Test-Logic-Reset, a 32-bit scratch DR at IR=0x03, and a state monitor.
- RESET after `rst` with `CLK_DIV`=2 → TMS 1,1,1,1,1,0 over 6 TCK; `rsp_valid` from cycle 25; `rsp_data`=0; TAP ends in Run-Test/Idle.
- RESET, then DR scan len 32 with data 0 → `rsp_data`=0x1234_5679, 37 TCK, TAP back in Run-Test/Idle.
- IR scan len 5 with data 0x03 → response bits[4:0]=0b00001 (IR capture), upper bits 0. Then DR scan 0xA5A5_0F0F followed by DR scan 0 → second `rsp_data`=0xA5A5_0F0F.
- Minimum length, DR scan `cmd_len_m1`=0 → exactly one shift cycle with TMS=1 on it; `rsp_data`[31:1]=0.
- Handshake: hold `rsp_ready`=0 for 10 cycles with `cmd_valid` high → `rsp_data` stable and `cmd_ready`=0 throughout. `cmd_ready`=1 the cycle after `rsp_ready` pulses.
- Assert `rst` mid-SHIFT → all outputs at reset values the same cycle, no response. Follow with RESET + IDCODE scan → 0x1234_5679.
